// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
    parameter int unsigned DW   = 32,
    parameter int unsigned SELW = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [DW-1:0]   req0_op1,
    input  logic [DW-1:0]   req0_op2,
    input  logic [SELW-1:0] req0_sel,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [DW-1:0]   req1_op1,
    input  logic [DW-1:0]   req1_op2,
    input  logic [SELW-1:0] req1_sel,

    output logic [DW-1:0]   alu_op1,
    output logic [DW-1:0]   alu_op2,
    output logic [SELW-1:0] alu_sel,
    input  logic [DW-1:0]   alu_res,
    input  logic            alu_zf,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [DW-1:0]   rsp_res,
    output logic            rsp_zf
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_op1;
    logic [DW-1:0]   r_op2;
    logic [SELW-1:0] r_sel;
    logic            r_gnt;
    logic            r_rsp0_valid;
    logic            r_rsp1_valid;
    logic [DW-1:0]   r_rsp_res;
    logic            r_rsp_zf;
`ifdef ALU_ARB_RR_EN
    logic            r_last;
`endif

    logic w_gnt0;
    logic w_gnt1;
    logic w_idle;
    logic w_exec;
    logic w_accept;
    logic w_rsp_take;

    always_comb begin
`ifdef ALU_ARB_RR_EN
        // On a tie, requester 1 wins only if requester 0 was granted last.
        w_gnt1 = req1_valid && (!req0_valid || !r_last);
`else
        w_gnt1 = req1_valid && !req0_valid;
`endif
        w_gnt0 = req0_valid && !w_gnt1;
    end

    assign w_idle     = (r_state == StIdle) && !rst;
    assign w_exec     = (r_state == StExec);
    assign w_accept   = w_idle && (req0_valid || req1_valid);
    assign w_rsp_take = r_gnt ? rsp1_ready : rsp0_ready;

    assign req0_ready = w_idle && w_gnt0;
    assign req1_ready = w_idle && w_gnt1;

    assign alu_op1 = w_exec ? r_op1 : '0;
    assign alu_op2 = w_exec ? r_op2 : '0;
    assign alu_sel = w_exec ? r_sel : '0;

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_res    = r_rsp_res;
    assign rsp_zf     = r_rsp_zf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_op1        <= '0;
            r_op2        <= '0;
            r_sel        <= '0;
            r_gnt        <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_res    <= '0;
            r_rsp_zf     <= 1'b0;
`ifdef ALU_ARB_RR_EN
            r_last       <= 1'b1;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op1   <= w_gnt1 ? req1_op1 : req0_op1;
                        r_op2   <= w_gnt1 ? req1_op2 : req0_op2;
                        r_sel   <= w_gnt1 ? req1_sel : req0_sel;
                        r_gnt   <= w_gnt1;
`ifdef ALU_ARB_RR_EN
                        r_last  <= w_gnt1;
`endif
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    r_rsp_res    <= alu_res;
                    r_rsp_zf     <= alu_zf;
                    r_rsp0_valid <= !r_gnt;
                    r_rsp1_valid <= r_gnt;
                    r_state      <= StResp;
                end
                StResp: begin
                    if (w_rsp_take) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
